popcount_accum: RTL and testbench
=================================

POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL have parameter BEATS, default 8: popcount beats accumulated per result (legal 1..1024).
REQ-002 SHALL have parameter ACC_W, default 16: accumulator and result width, signed two's complement (legal 8..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 SHALL have port in_data  input  16  signed bipolar popcount from the 8-bit popcount stage, sign-extended.
REQ-008 SHALL have port acc_clr  input  1  synchronous abort of the current accumulation.
REQ-009 SHALL have port threshold  input  ACC_W  signed binarization threshold.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_sum  output  ACC_W  signed accumulated sum.
REQ-013 SHALL have port out_bit  output  1  binarized activation: 1 when out_sum >= threshold (signed compare).

Function
REQ-014 SHALL implement a two-state FSM: ACC (collecting beats) and OUT (holding the result).
REQ-015 in_ready SHALL be 1 only in ACC with acc_clr=0; in OUT it SHALL be 0.
REQ-016 A beat SHALL transfer when in_valid and in_ready are both 1; in_data[ACC_W-1:0] sign-extended or truncated to ACC_W SHALL be added to the accumulator, and the beat counter SHALL increment.
REQ-017 On the transfer of beat BEATS, acc+in_data SHALL be registered into out_sum, out_bit SHALL be computed against threshold sampled in that cycle, and the next cycle SHALL be OUT with out_valid=1 (latency 1 cycle after the last beat).
REQ-018 In OUT, out_sum, out_bit and out_valid SHALL hold stable until out_valid and out_ready are both 1; the following cycle SHALL be ACC with accumulator=0, counter=0, out_valid=0.
REQ-019 Idle cycles (in_valid=0) in ACC SHALL leave the accumulator and counter unchanged.
REQ-020 acc_clr=1 in ACC SHALL zero the accumulator and counter next cycle; no beat transfers in that cycle.
REQ-021 acc_clr=1 in OUT SHALL be ignored; the pending result SHALL not be lost.
REQ-022 With BEATS=1, every accepted beat SHALL produce a result.
REQ-023 Without ACC_SAT_EN, addition SHALL wrap modulo 2^ACC_W.
REQ-024 Minimum period per result SHALL be BEATS+1 cycles with out_ready held at 1.

Reset
REQ-025 rst_n=0 SHALL immediately force state=ACC, accumulator=0, counter=0, out_valid=0, out_sum=0, out_bit=0.
REQ-026 Reset asserted mid-accumulation or in OUT SHALL discard all partial and pending data; the first beat after release SHALL start a fresh result.

Configuration
REQ-027 Macro POPCOUNT_ACCUM_SAT_EN: when defined, every addition SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and the clamped value SHALL continue to accumulate.
REQ-028 Without POPCOUNT_ACCUM_SAT_EN, no clamp logic SHALL be present and REQ-023 SHALL apply.

Verification
REQ-029 Defaults; 8 beats of in_data=+7, threshold=0, out_ready=1 -> out_valid 1 cycle after beat 8, out_sum=56, out_bit=1, in_ready=0 for one cycle.
REQ-030 Defaults; beats -8,-8,-8,-8,+2,+2,+2,+2, threshold=-24 -> out_sum=-24, out_bit=1; rerun with threshold=-23 -> out_bit=0.
REQ-031 Defaults; result ready, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_sum stable throughout; out_ready=1 -> ACC next cycle, next result independent of the first.
REQ-032 Defaults; 3 beats of +5, then acc_clr=1 alongside in_valid=1, then 8 beats of +1 -> out_sum=8 (the beat in the clr cycle is not accepted).
REQ-033 BEATS=32, ACC_W=8, 32 beats of +7 -> out_sum=127 with POPCOUNT_ACCUM_SAT_EN, out_sum=-32 without.
REQ-034 Defaults; rst_n pulsed low after 4 beats, then 8 beats of +1 -> out_valid=0 during reset, out_sum=8.

Source files
------------

// File: rtl/popcount_accum.sv
// popcount_accum: accumulates BEATS signed popcount beats into one signed sum plus a thresholded activation bit.
// Define POPCOUNT_ACCUM_SAT_EN to clamp every addition instead of wrapping.
module popcount_accum #(
  parameter int BEATS = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_data,
  input  logic                    acc_clr,
  input  logic signed [ACC_W-1:0] threshold,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_bit
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {ACC, OUT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic signed [ACC_W-1:0] acc, din, nxt;
  logic last;
  assign din = ACC_W'(in_data);
`ifdef POPCOUNT_ACCUM_SAT_EN
  logic signed [ACC_W:0] ext;
  assign ext = {acc[ACC_W-1], acc} + {din[ACC_W-1], din};
  // sign-bit disagreement in the widened sum marks overflow; pick the rail by the true sign
  assign nxt = (ext[ACC_W] != ext[ACC_W-1]) ? {ext[ACC_W], {(ACC_W-1){~ext[ACC_W]}}} : ext[ACC_W-1:0];
`else
  assign nxt = acc + din;
`endif
  assign last = cnt == CW'(BEATS - 1);
  assign in_ready = (state == ACC) && !acc_clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
    end else if (state == ACC) begin
      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_valid && last) begin
        out_sum   <= nxt;
        out_bit   <= nxt >= threshold;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        state     <= OUT;
      end else if (in_valid) begin
        acc <= nxt;
        cnt <= cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      state     <= ACC;
    end
  end
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed checks of the default build plus a narrow BEATS=32/ACC_W=8 instance.
module tb_popcount_accum;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, acc_clr = 0, out_ready = 1;
  logic signed [15:0] in_data = 0;
  logic signed [15:0] threshold = 0;
  logic in_ready, out_valid, out_bit;
  logic signed [15:0] out_sum;
  logic v8 = 0, r8, ov8, ob8;
  logic signed [15:0] d8 = 0;
  logic signed [7:0] s8;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  popcount_accum dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_clr(acc_clr), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_bit(out_bit));

  popcount_accum #(.BEATS(32), .ACC_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_data(d8), .acc_clr(1'b0), .threshold(8'sd0), .out_valid(ov8), .out_ready(1'b1), .out_sum(s8),
    .out_bit(ob8));

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    else pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v);
    in_valid = 1;
    in_data = v;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    threshold = 0;
    out_ready = 1;
    for (int i = 0; i < 7; i++) send(7);
    chk("basic_no_early_valid", out_valid, 0);
    send(7);
    chk("basic_valid", out_valid, 1);
    chk("basic_sum", out_sum, 56);
    chk("basic_bit", out_bit, 1);
    chk("basic_in_ready_low", in_ready, 0);
    tick();
    chk("basic_valid_drop", out_valid, 0);
    chk("basic_in_ready_back", in_ready, 1);
  endtask

  task automatic test_threshold();
    logic signed [15:0] v [8] = '{-8, -8, -8, -8, 2, 2, 2, 2};
    threshold = -24;
    for (int i = 0; i < 8; i++) send(v[i]);
    chk("thr_sum", out_sum, -24);
    chk("thr_bit_eq", out_bit, 1);
    tick();
    threshold = -23;
    for (int i = 0; i < 8; i++) send(v[i]);
    chk("thr_sum2", out_sum, -24);
    chk("thr_bit_below", out_bit, 0);
    tick();
    threshold = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(3);
    in_valid = 1;
    in_data = 100;
    acc_clr = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum_hold", out_sum, 24);
      chk("bp_valid_hold", out_valid, 1);
      tick();
    end
    acc_clr = 0;
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("bp_released", out_valid, 0);
    for (int i = 0; i < 8; i++) send(1);
    chk("bp_next_sum", out_sum, 8);
    tick();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) send(5);
    acc_clr = 1;
    in_valid = 1;
    in_data = 5;
    #1;
    chk("clr_in_ready", in_ready, 0);
    tick();
    acc_clr = 0;
    in_valid = 0;
    for (int i = 0; i < 7; i++) send(1);
    chk("clr_no_early", out_valid, 0);
    send(1);
    chk("clr_valid", out_valid, 1);
    chk("clr_sum", out_sum, 8);
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      send(2);
      tick();
      tick();
    end
    for (int i = 0; i < 3; i++) send(2);
    chk("idle_no_early", out_valid, 0);
    send(2);
    chk("idle_sum", out_sum, 16);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) send(9);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 8; i++) send(1);
    chk("mid_rst_sum_after", out_sum, 8);
    chk("mid_rst_valid_after", out_valid, 1);
    out_ready = 0;
    tick();
    rst_n = 0;
    #1;
    chk("out_rst_valid", out_valid, 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    tick();
  endtask

  task automatic test_narrow();
    for (int i = 0; i < 32; i++) begin
      v8 = 1;
      d8 = 7;
      tick();
    end
    v8 = 0;
    chk("n8_valid", ov8, 1);
`ifdef POPCOUNT_ACCUM_SAT_EN
    chk("n8_sum", s8, 127);
    chk("n8_bit", ob8, 1);
`else
    chk("n8_sum", s8, -32);
    chk("n8_bit", ob8, 0);
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_backpressure();
    test_clear();
    test_idle();
    test_reset_mid();
    test_narrow();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
